// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: ALU and load writeback requests, issue-side hazard
// queries, and the registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_wd;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_ready;

  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  we;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] wd;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    output alu_ready,
    input  mem_valid, mem_rd, mem_wd,
    output mem_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output we, rd, wd
  );

  // Writeback sources, issue logic and register file side
  modport master (
    output alu_valid, alu_rd, alu_wd,
    input  alu_ready,
    output mem_valid, mem_rd, mem_wd,
    input  mem_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  we, rd, wd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a pending-write
// scoreboard for RAW/WAW stalls. Optional conflict counter: define ARB_CONFLICT_CNT_EN.
module wb_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
`ifdef ARB_CONFLICT_CNT_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
`ifdef ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] conflict_cnt
`endif
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  // rr_ptr: 0 = ALU favoured on a conflict, 1 = load unit favoured
  logic                  rr_ptr_reg;
  logic                  rr_ptr_next;

  logic                  alu_ready_c;
  logic                  mem_ready_c;
  logic                  grant;
  logic                  conflict;
  logic [ADDR_WIDTH-1:0] grant_rd;
  logic [DATA_WIDTH-1:0] grant_wd;

  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic [DATA_WIDTH-1:0] wd_reg;

  logic [NREG-1:0]       pending_reg;
  logic [NREG-1:0]       pending_next;
  logic                  iss_ready_c;
  logic                  issue_set;

  // ---------------- arbitration: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= 1'b0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // ---------------- arbitration: next state ----------------
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    // The loser of a conflict is favoured next time, bounding starvation to one cycle
    if (conflict) begin
      rr_ptr_next = ~rr_ptr_reg;
    end
  end

  // ---------------- arbitration: outputs ----------------
  always_comb begin
    conflict    = bus.alu_valid && bus.mem_valid;
    alu_ready_c = bus.alu_valid && (!bus.mem_valid || !rr_ptr_reg);
    mem_ready_c = bus.mem_valid && (!bus.alu_valid ||  rr_ptr_reg);
    grant       = alu_ready_c || mem_ready_c;
    grant_rd    = mem_ready_c ? bus.mem_rd : bus.alu_rd;
    grant_wd    = mem_ready_c ? bus.mem_wd : bus.alu_wd;
  end

  assign bus.alu_ready = alu_ready_c;
  assign bus.mem_ready = mem_ready_c;

  // ---------------- registered write port ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg <= 1'b0;
      rd_reg <= '0;
      wd_reg <= '0;
    end else begin
      // Writes to x0 are accepted from the source but never reach the register file
      we_reg <= grant && (grant_rd != '0);
      if (grant && (grant_rd != '0)) begin
        rd_reg <= grant_rd;
        wd_reg <= grant_wd;
      end
    end
  end

  assign bus.we = we_reg;
  assign bus.rd = rd_reg;
  assign bus.wd = wd_reg;

  // ---------------- pending-write scoreboard ----------------
  assign iss_ready_c = !pending_reg[bus.iss_rd] || (bus.iss_rd == '0);
  assign issue_set   = bus.iss_valid && iss_ready_c && (bus.iss_rd != '0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    if (gi == 0) begin : g_x0
      assign pending_next[gi] = 1'b0;
    end else begin : g_reg
      logic set_hit;
      logic clr_hit;
      assign set_hit = issue_set && (bus.iss_rd == ADDR_WIDTH'(gi));
      assign clr_hit = grant && (grant_rd == ADDR_WIDTH'(gi));
      assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Busy flags see the scoreboard before this cycle's update; no bypass
  assign bus.iss_ready = iss_ready_c;
  assign bus.rs1_busy  = pending_reg[bus.rs1];
  assign bus.rs2_busy  = pending_reg[bus.rs2];

`ifdef ARB_CONFLICT_CNT_EN
  logic [CNT_WIDTH-1:0] conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if (conflict && (conflict_cnt_reg != '1)) begin
      conflict_cnt_reg <= conflict_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus randomized bench for wb_port_arbiter against a high-level model
// of arbitration, the write port and the pending scoreboard.
module tb_wb_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  wb_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  wb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          pend [32];
  bit          fav_mem;
  int          conflicts;
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;

  // Observations taken mid-cycle, before the active edge
  logic obs_alu_ready, obs_mem_ready, obs_iss_ready, obs_rs1_busy, obs_rs2_busy;
  bit   alu_acc, mem_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check combinational outputs, clock, update model, check registered outputs
  task automatic cycle(input bit do_rst);
    int          winner;  // 0 none, 1 ALU, 2 load unit
    bit          iss_ok;
    bit          both;
    bit          iss_v;
    logic [4:0]  wrd;
    logic [31:0] wwd;
    logic [4:0]  ird;
    rst = do_rst;
    #1;
    both = bus.alu_valid && bus.mem_valid;
    if (both)               winner = fav_mem ? 2 : 1;
    else if (bus.alu_valid) winner = 1;
    else if (bus.mem_valid) winner = 2;
    else                    winner = 0;
    wrd    = (winner == 2) ? bus.mem_rd : bus.alu_rd;
    wwd    = (winner == 2) ? bus.mem_wd : bus.alu_wd;
    ird    = bus.iss_rd;
    iss_v  = bus.iss_valid;
    iss_ok = !pend[ird] || (ird == 0);

    obs_alu_ready = bus.alu_ready;
    obs_mem_ready = bus.mem_ready;
    obs_iss_ready = bus.iss_ready;
    obs_rs1_busy  = bus.rs1_busy;
    obs_rs2_busy  = bus.rs2_busy;
    if (!do_rst) begin
      chk("alu_ready", bus.alu_ready, winner == 1);
      chk("mem_ready", bus.mem_ready, winner == 2);
      chk("iss_ready", bus.iss_ready, iss_ok);
    end
    chk("rs1_busy", bus.rs1_busy, pend[bus.rs1]);
    chk("rs2_busy", bus.rs2_busy, pend[bus.rs2]);
    alu_acc = !do_rst && (winner == 1);
    mem_acc = !do_rst && (winner == 2);

    @(posedge clk);
    #1;
    if (do_rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      fav_mem   = 1'b0;
      conflicts = 0;
      exp_we    = 1'b0;
      exp_rd    = '0;
      exp_wd    = '0;
    end else begin
      exp_we = 1'b0;
      if (winner != 0) begin
        pend[wrd] = 1'b0;
        if (wrd != 0) begin
          exp_we = 1'b1;
          exp_rd = wrd;
          exp_wd = wwd;
        end
      end
      if (iss_v && iss_ok && ird != 0) pend[ird] = 1'b1;
      if (both) begin
        fav_mem = (winner == 1);  // loser is favoured next
        if (conflicts < 65535) conflicts++;
      end
    end
    chk("we", bus.we, exp_we);
    if (exp_we || do_rst) begin
      chk("rd", bus.rd, exp_rd);
      chk("wd", bus.wd, exp_wd);
    end
`ifdef ARB_CONFLICT_CNT_EN
    chk("conflict_cnt", conflict_cnt, conflicts);
`endif
    $display("cycle rst=%0d alu=%0d/%0d mem=%0d/%0d iss=%0d/%0d -> we=%0d rd=%0d wd=0x%08h",
             do_rst, bus.alu_valid, alu_acc, bus.mem_valid, mem_acc,
             iss_v, ird, bus.we, bus.rd, bus.wd);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_wd = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_wd = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cycle(1);
    cycle(1);
    chk("reset_we", bus.we, 1'b0);
    chk("reset_rd", bus.rd, 5'd0);
    chk("reset_wd", bus.wd, 32'd0);

    // 1: single ALU write, latency one
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wd = 32'hDEADBEEF;
    cycle(0);
    chk("t1_alu_ready", obs_alu_ready, 1'b1);
    chk("t1_we", bus.we, 1'b1);
    chk("t1_rd", bus.rd, 5'd5);
    chk("t1_wd", bus.wd, 32'hDEADBEEF);
    bus.alu_valid = 1'b0;
    cycle(0);
    chk("t1_we_off", bus.we, 1'b0);

    // 2: three conflict cycles after reset alternate ALU, MEM, ALU
    cycle(1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'hA1A1A1A1;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_wd = 32'hB2B2B2B2;
    cycle(0);
    chk("t2_g0_rd", bus.rd, 5'd1);
    cycle(0);
    chk("t2_g1_rd", bus.rd, 5'd2);
    cycle(0);
    chk("t2_g2_rd", bus.rd, 5'd1);
`ifdef ARB_CONFLICT_CNT_EN
    chk("t2_cnt", conflict_cnt, 16'd3);
`endif
    idle_inputs();

    // 3: issue rd=7, stall on it, clear via load grant
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cycle(0);
    bus.rs1 = 5'd7;
    cycle(0);
    chk("t3_rs1_busy", obs_rs1_busy, 1'b1);
    chk("t3_iss_stall", obs_iss_ready, 1'b0);
    bus.iss_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_wd = 32'h77777777;
    cycle(0);
    chk("t3_busy_same_cycle", obs_rs1_busy, 1'b1);
    bus.mem_valid = 1'b0;
    cycle(0);
    chk("t3_busy_cleared", obs_rs1_busy, 1'b0);
    idle_inputs();

    // 4: x0 writes are accepted but suppressed; issue to x0 never stalls
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_wd = 32'h1234;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    cycle(0);
    chk("t4_alu_ready", obs_alu_ready, 1'b1);
    chk("t4_iss_ready", obs_iss_ready, 1'b1);
    chk("t4_we0", bus.we, 1'b0);
    idle_inputs();
    cycle(0);
    chk("t4_we1", bus.we, 1'b0);
    chk("t4_x0_busy", obs_rs1_busy, 1'b0);

    // 5: reset while a write is in flight and reg 3 is pending (rr_ptr left at 1)
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_wd = 32'h88888888;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    cycle(0);
    chk("t5_pre_we", bus.we, 1'b1);
    idle_inputs();
    bus.rs1 = 5'd3;
    cycle(1);
    chk("t5_we", bus.we, 1'b0);
    chk("t5_rd", bus.rd, 5'd0);
    chk("t5_wd", bus.wd, 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_wd = 32'h66666666;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_wd = 32'h88888888;
    cycle(0);
    chk("t5_busy", obs_rs1_busy, 1'b0);
    chk("t5_rr_alu", obs_alu_ready, 1'b1);
    idle_inputs();
    cycle(0);

    // 6: set of reg 4 and clear of reg 9 in the same cycle
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cycle(0);
    bus.iss_rd = 5'd4;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_wd = 32'h99999999;
    cycle(0);
    idle_inputs();
    bus.rs1 = 5'd4; bus.rs2 = 5'd9;
    cycle(0);
    chk("t6_pend4", obs_rs1_busy, 1'b1);
    chk("t6_pend9", obs_rs2_busy, 1'b0);

    // Randomized traffic; sources hold requests until accepted
    cycle(1);
    alu_acc = 1'b1;
    mem_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.alu_valid || alu_acc) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 7));
        bus.alu_wd    = $urandom;
      end
      if (!bus.mem_valid || mem_acc) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = 5'($urandom_range(0, 7));
        bus.mem_wd    = $urandom;
      end
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.rs1       = 5'($urandom_range(0, 7));
      bus.rs2       = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
